firtap_loader: RTL

//  Coefficient writer for the adjustable-tap FIR chain. Accepts one filter's worth of

---
 rtl/fir_pkg.sv | 14 +
 rtl/firtap_loader.sv | 113 +++++++++++
 2 files changed

// File: rtl/fir_pkg.sv
// Shared definitions for the adjustable-tap FIR chain:
// default widths and the coefficient loader state encoding.
package fir_pkg;

  localparam int unsigned FIR_TW    = 16;
  localparam int unsigned FIR_NTAPS = 128;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_FLUSH = 3'd2;
  localparam logic [2:0] ST_DRAIN = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

endpackage

// File: rtl/firtap_loader.sv
// Streams one filter's coefficients into the tap chain, issuing
// exactly NTAPS shifts per load with zero padding / excess discard.
module firtap_loader
  import fir_pkg::*;
#(
  parameter int unsigned TW      = FIR_TW,
  parameter int unsigned NTAPS   = FIR_NTAPS,
  parameter int unsigned LGNTAPS = $clog2(NTAPS + 1)
) (
  input  logic               i_clk,
  input  logic               i_reset_n,
  input  logic               i_start,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic [TW-1:0]      i_coeff,
  input  logic               i_last,
  output logic               o_tap_wr,
  output logic [TW-1:0]      o_tap,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_err,
  output logic [LGNTAPS-1:0] o_count
);

  localparam logic [LGNTAPS-1:0] NT = LGNTAPS'(NTAPS);

  logic [2:0]         state_q, state_d;
  logic [LGNTAPS-1:0] count_q, count_d;
  logic [LGNTAPS-1:0] count_inc;
  logic [TW-1:0]      tap_q, tap_d;
  logic               tap_wr_q, tap_wr_d;
  logic               ready_q, ready_d;
  logic               err_q, err_d;
  logic               accept;

  assign accept    = i_valid && ready_q;
  assign count_inc = (count_q == NT) ? count_q : count_q + 1'b1;

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    tap_d    = tap_q;
    tap_wr_d = 1'b0;
    err_d    = err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          count_d = '0;
          err_d   = 1'b0;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (accept) begin
          tap_d    = i_coeff;
          tap_wr_d = 1'b1;
          count_d  = count_inc;
          if (count_inc == NT) begin
            if (i_last) begin
              state_d = ST_DONE;
            end else begin
              err_d   = 1'b1;
              state_d = ST_DRAIN;
            end
          end else if (i_last) begin
            state_d = ST_FLUSH;
          end
        end
      end
      ST_FLUSH: begin
        tap_d    = '0;
        tap_wr_d = 1'b1;
        count_d  = count_inc;
        if (count_inc == NT) state_d = ST_DONE;
      end
      ST_DRAIN: begin
        if (accept && i_last) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // ready is registered, so it is derived from the next state
  assign ready_d = (state_d == ST_LOAD) || (state_d == ST_DRAIN);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q  <= ST_IDLE;
      count_q  <= '0;
      tap_q    <= '0;
      tap_wr_q <= 1'b0;
      ready_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      tap_q    <= tap_d;
      tap_wr_q <= tap_wr_d;
      ready_q  <= ready_d;
      err_q    <= err_d;
    end
  end

  assign o_ready  = ready_q;
  assign o_tap_wr = tap_wr_q;
  assign o_tap    = tap_q;
  assign o_busy   = (state_q != ST_IDLE);
  assign o_done   = (state_q == ST_DONE);
  assign o_err    = err_q;
  assign o_count  = count_q;

endmodule
